muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-002 Parameter WIDTH SHALL default to 16 and set the operand width and the LO/HI register width.
REQ-003 Port clock: input, 1 bit, rising-edge clock for all state.
REQ-004 Port reset: input, 1 bit, asynchronous active-high clear of all state and outputs.
REQ-005 Port start: input, 1 bit, request to begin an operation, sampled only in IDLE.
REQ-006 Port op: input, 1 bit, operation select: 0 = unsigned multiply, 1 = unsigned divide.
REQ-007 Port operand_a: input, WIDTH bits, multiplicand or dividend, captured when start is accepted.
REQ-008 Port operand_b: input, WIDTH bits, multiplier or divisor, captured when start is accepted.
REQ-009 Port cancel: input, 1 bit, abort the running operation.
REQ-010 Port busy: output, 1 bit, high in RUN and WRITE.
REQ-011 Port done: output, 1 bit, one-cycle pulse coincident with the write.
REQ-012 Ports write_lo and write_hi: outputs, 1 bit each, write strobes to the LO/HI register file; they are always asserted together.
REQ-013 Ports value_lo and value_hi: outputs, WIDTH bits each, write data.
REQ-014 Ports negative, overflow, carry and zero: outputs, 1 bit each, status flags valid while write_lo is high and 0 otherwise.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN and WRITE.
REQ-016 In IDLE, start=1 SHALL capture op, operand_a and operand_b, clear the iteration counter and move to RUN; for a divide with operand_b=0 it SHALL move directly to WRITE instead.
REQ-017 RUN SHALL last exactly WIDTH cycles, with one iteration per cycle; a 5-bit counter SHALL count 0..WIDTH-1, and the FSM SHALL move to WRITE when the counter reaches WIDTH-1.
REQ-018 Multiply SHALL use shift-add and produce the 2*WIDTH-bit product as {value_hi, value_lo}, with no truncation.
REQ-019 Divide SHALL use restoring division and produce value_lo = quotient and value_hi = remainder.
REQ-020 Divide by zero SHALL produce value_lo = all ones, value_hi = operand_a and overflow = 1.
REQ-021 WRITE SHALL last exactly 1 cycle: write_lo, write_hi and done are high, value and flag outputs are stable, and the next state is IDLE.
REQ-022 Latency SHALL be: WRITE is the 17th cycle after the start-sampling edge in the normal case, and the 1st cycle in the divide-by-zero case.
REQ-023 Flag values SHALL be: zero = 1 iff {value_hi, value_lo} == 0; negative = value_hi[WIDTH-1]; carry = 0; overflow = 1 only on divide by zero.
REQ-024 start while busy SHALL be ignored without queuing, and operand changes while busy SHALL have no effect.
REQ-025 cancel in RUN SHALL return the FSM to IDLE at the next edge with no write; cancel in WRITE SHALL be ignored (the write completes); cancel in IDLE SHALL have no effect.
REQ-026 If start and cancel are high together in IDLE, the start SHALL be accepted.
REQ-027 write_lo, write_hi and done SHALL never assert outside WRITE and SHALL never assert for two consecutive cycles.

Reset
REQ-028 Asserting reset in any state, including mid-RUN, SHALL immediately force the FSM to IDLE and clear the counter and operand/accumulator registers.
REQ-029 During reset, busy, done, write_lo, write_hi, value_lo, value_hi and all flags SHALL be 0.
REQ-030 An operation interrupted by reset SHALL produce no write after reset deasserts.

Structure
REQ-031 Shared package muldiv_pkg SHALL hold the state enum (IDLE, RUN, WRITE), op encodings OP_MUL = 0 and OP_DIV = 1, and the constants WIDTH_DEF = 16 and ITER_CNT = 16.
REQ-032 Sub-module muldiv_datapath SHALL hold the accumulator, shift and add/subtract logic with iterate and load controls, while the FSM and counter stay in muldiv_sequencer.

Verification
REQ-033 Multiply 0x1234 * 0x5678 -> value_hi = 0x0626, value_lo = 0x0060, zero = 0, negative = 0, with the write in cycle 17.
REQ-034 Multiply 0xFFFF * 0xFFFF -> value_hi = 0xFFFE, value_lo = 0x0001, negative = 1; multiply 0x0000 * 0x1234 -> zero = 1.
REQ-035 Divide 100 / 7 -> value_lo = 0x000E, value_hi = 0x0002, overflow = 0, with the write in cycle 17.
REQ-036 Divide 0x1234 / 0 -> value_lo = 0xFFFF, value_hi = 0x1234, overflow = 1, with the write in cycle 1 and busy for 1 cycle.
REQ-037 A second start at RUN cycle 3 is ignored with one write only; cancel at RUN cycle 5 -> busy low next cycle and no write_lo/write_hi.
REQ-038 Asynchronous reset asserted mid-RUN (cycle 8) -> all outputs 0 immediately; no write after release; a new multiply 3 * 4 then gives value_lo = 0x000C.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned ITER_CNT  = 16;
  localparam int unsigned CNT_W     = 5;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between a requester and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = muldiv_pkg::WIDTH_DEF
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             write_lo;
  logic             write_hi;
  logic [WIDTH-1:0] value_lo;
  logic [WIDTH-1:0] value_hi;
  logic             negative;
  logic             overflow;
  logic             carry;
  logic             zero;

  modport master (
    output start, op, operand_a, operand_b, cancel,
    input  busy, done, write_lo, write_hi, value_lo, value_hi,
           negative, overflow, carry, zero
  );

  modport slave (
    input  start, op, operand_a, operand_b, cancel,
    output busy, done, write_lo, write_hi, value_lo, value_hi,
           negative, overflow, carry, zero
  );
endinterface

// File: rtl/muldiv_datapath.sv
// Accumulator for shift-add multiply and restoring divide; next_*_c is the
// accumulator value after one more iteration.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             iterate,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] next_lo_c,
  output logic [WIDTH-1:0] next_hi_c
);

  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] divisor;
  logic             op_q;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   shifted_c;
  logic [WIDTH:0]   diff_c;

  // Multiply: {hi,lo} shifts right with the partial sum; divide: remainder in hi, quotient shifts into lo.
  always_comb begin
    sum_c     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, divisor} : (WIDTH+1)'(0));
    shifted_c = {acc_hi, acc_lo[WIDTH-1]};
    diff_c    = shifted_c - {1'b0, divisor};
    next_hi_c = sum_c[WIDTH:1];
    next_lo_c = {sum_c[0], acc_lo[WIDTH-1:1]};
    if (op_q == OP_DIV) begin
      if (!diff_c[WIDTH]) begin
        next_hi_c = diff_c[WIDTH-1:0];
        next_lo_c = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        next_hi_c = shifted_c[WIDTH-1:0];
        next_lo_c = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_hi  <= '0;
      acc_lo  <= '0;
      divisor <= '0;
      op_q    <= OP_MUL;
    end else if (load) begin
      acc_hi  <= '0;
      acc_lo  <= operand_a;
      divisor <= operand_b;
      op_q    <= op;
    end else if (iterate) begin
      acc_hi  <= next_hi_c;
      acc_lo  <= next_lo_c;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply/divide: IDLE -> RUN (WIDTH iterations) -> WRITE,
// with divide-by-zero short-circuiting straight to WRITE.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input logic          clock,
  input logic          reset,
  muldiv_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_WRITE = WRITE;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             load_c;
  logic             iterate_c;
  logic             div0_c;
  logic             wr_c;
  logic [WIDTH-1:0] next_lo;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] res_lo_c;
  logic [WIDTH-1:0] res_hi_c;
  logic             ovf_c;

  logic             busy_q;
  logic             wr_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic             neg_q;
  logic             ovf_q;
  logic             zero_q;

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clock     (clock),
    .reset     (reset),
    .load      (load_c),
    .iterate   (iterate_c),
    .op        (bus.op),
    .operand_a (bus.operand_a),
    .operand_b (bus.operand_b),
    .next_lo_c (next_lo),
    .next_hi_c (next_hi)
  );

  // Next state; cancel only matters in RUN, and start wins over cancel in IDLE.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    iterate_c = 1'b0;
    div0_c    = (bus.op == OP_DIV) && (bus.operand_b == '0);
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          load_c    = 1'b1;
          state_nxt = div0_c ? S_WRITE : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.cancel) begin
          state_nxt = S_IDLE;
        end else begin
          iterate_c = 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state_nxt = S_WRITE;
        end
      end
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result captured on entry to WRITE: the final iteration, or the divide-by-zero pattern from IDLE.
  always_comb begin
    wr_c     = (state_nxt == S_WRITE);
    res_lo_c = next_lo;
    res_hi_c = next_hi;
    ovf_c    = 1'b0;
    if (state == S_IDLE) begin
      res_lo_c = '1;
      res_hi_c = bus.operand_a;
      ovf_c    = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      wr_q   <= 1'b0;
      lo_q   <= '0;
      hi_q   <= '0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      if (load_c)         cnt <= '0;
      else if (iterate_c) cnt <= cnt + CNT_W'(1);
      busy_q <= (state_nxt != S_IDLE);
      wr_q   <= wr_c;
      if (wr_c) begin
        lo_q   <= res_lo_c;
        hi_q   <= res_hi_c;
        neg_q  <= res_hi_c[WIDTH-1];
        ovf_q  <= ovf_c;
        zero_q <= ({res_hi_c, res_lo_c} == '0);
      end else begin
        lo_q   <= '0;
        hi_q   <= '0;
        neg_q  <= 1'b0;
        ovf_q  <= 1'b0;
        zero_q <= 1'b0;
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = wr_q;
  assign bus.write_lo = wr_q;
  assign bus.write_hi = wr_q;
  assign bus.value_lo = lo_q;
  assign bus.value_hi = hi_q;
  assign bus.negative = neg_q;
  assign bus.overflow = ovf_q;
  assign bus.carry    = 1'b0;
  assign bus.zero     = zero_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases, randomized ops
// against an arithmetic reference, cancel/ignore/reset scenarios.
module tb_muldiv_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  muldiv_sequencer_if #(.WIDTH(16)) bus ();

  muldiv_sequencer #(.WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [39:0] all_outs();
    return {bus.busy, bus.done, bus.write_lo, bus.write_hi, bus.value_lo, bus.value_hi,
            bus.negative, bus.overflow, bus.carry, bus.zero};
  endfunction

  // Reference: plain arithmetic on the operands.
  task automatic model(input logic o, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] lo, output logic [15:0] hi,
                       output logic [3:0] flg, output int lat);
    logic [31:0] r;
    logic        ov;
    ov  = 1'b0;
    lat = 17;
    if (o == 1'b0)       r = 32'(a) * 32'(b);
    else if (b == 16'h0) begin r = {a, 16'hFFFF}; ov = 1'b1; lat = 1; end
    else                 r = {16'(a % b), 16'(a / b)};
    lo  = r[15:0];
    hi  = r[31:16];
    flg = {r[31], ov, 1'b0, r == 32'h0};
  endtask

  // Issue one op and observe 30 cycles; bad counts strobe-disagreement or back-to-back writes.
  task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b, input bit scramble,
                        output int lat, output logic [15:0] lo, output logic [15:0] hi,
                        output logic [3:0] flg, output int busy_cyc, output int writes, output int bad);
    logic prev_wr;
    bus.start = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b;
    @(posedge clock); #1;
    bus.start = 1'b0;
    lat = -1; lo = 'x; hi = 'x; flg = 'x; busy_cyc = 0; writes = 0; bad = 0; prev_wr = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.write_hi !== bus.write_lo || bus.done !== bus.write_lo) bad++;
      if (bus.write_lo === 1'b1) begin
        if (prev_wr) bad++;
        writes++;
        if (lat < 0) begin
          lat = n; lo = bus.value_lo; hi = bus.value_hi;
          flg = {bus.negative, bus.overflow, bus.carry, bus.zero};
        end
      end else if (flg !== 4'bxxxx || lat < 0) begin
        if ({bus.negative, bus.overflow, bus.carry, bus.zero} !== 4'b0) bad++;
      end
      prev_wr = bus.write_lo;
      if (scramble) begin
        bus.operand_a = 16'($urandom); bus.operand_b = 16'($urandom); bus.op = 1'($urandom);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.cancel = 1'b0; bus.op = 1'b0; bus.operand_a = '0; bus.operand_b = '0;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (all_outs() !== 40'h0) begin n_fail++; $display("FAIL reset_outputs got=%h want=0", all_outs()); end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if (all_outs() !== 40'h0) begin n_fail++; $display("FAIL post_reset_idle got=%h want=0", all_outs()); end
  endtask

  task automatic test_directed();
    logic        t_op [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] t_a  [5]  = '{16'h1234, 16'hFFFF, 16'h0000, 16'd100, 16'h1234};
    logic [15:0] t_b  [5]  = '{16'h5678, 16'hFFFF, 16'h1234, 16'd7, 16'h0000};
    logic [15:0] t_lo [5]  = '{16'h0060, 16'h0001, 16'h0000, 16'h000E, 16'hFFFF};
    logic [15:0] t_hi [5]  = '{16'h0626, 16'hFFFE, 16'h0000, 16'h0002, 16'h1234};
    logic [3:0]  t_fl [5]  = '{4'b0000, 4'b1000, 4'b0001, 4'b0000, 4'b0100};
    int          t_lat [5] = '{17, 17, 17, 17, 1};
    int lat, bc, wr, bad;
    logic [15:0] lo, hi;
    logic [3:0] flg;
    for (int i = 0; i < 5; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 1'b0, lat, lo, hi, flg, bc, wr, bad);
      n_checks++;
      if (lat !== t_lat[i]) begin n_fail++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, t_lat[i]); end
      n_checks++;
      if ({hi, lo} !== {t_hi[i], t_lo[i]}) begin
        n_fail++; $display("FAIL dir%0d_value got=%h_%h want=%h_%h", i, hi, lo, t_hi[i], t_lo[i]);
      end
      n_checks++;
      if (flg !== t_fl[i]) begin n_fail++; $display("FAIL dir%0d_flags got=%b want=%b", i, flg, t_fl[i]); end
      n_checks++;
      if (bc !== t_lat[i]) begin n_fail++; $display("FAIL dir%0d_busy_cycles got=%0d want=%0d", i, bc, t_lat[i]); end
      n_checks++;
      if (wr !== 1 || bad !== 0) begin n_fail++; $display("FAIL dir%0d_strobes writes=%0d bad=%0d want 1/0", i, wr, bad); end
    end
  endtask

  task automatic test_random();
    int lat, bc, wr, bad, elat;
    logic [15:0] a, b, lo, hi, elo, ehi;
    logic [3:0] flg, eflg;
    logic o;
    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom);
      a = 16'($urandom);
      case ($urandom_range(5, 0))
        0:       b = 16'h0;
        1:       b = 16'($urandom_range(15, 1));
        default: b = 16'($urandom);
      endcase
      model(o, a, b, elo, ehi, eflg, elat);
      run_op(o, a, b, 1'b1, lat, lo, hi, flg, bc, wr, bad);
      n_checks++;
      if (lat !== elat || bc !== elat) begin
        n_fail++; $display("FAIL rnd%0d_timing op=%0d lat=%0d busy=%0d want=%0d", i, o, lat, bc, elat);
      end
      n_checks++;
      if ({hi, lo, flg} !== {ehi, elo, eflg}) begin
        n_fail++;
        $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h_%h/%b want=%h_%h/%b", i, o, a, b, hi, lo, flg, ehi, elo, eflg);
      end
      n_checks++;
      if (wr !== 1 || bad !== 0) begin n_fail++; $display("FAIL rnd%0d_strobes writes=%0d bad=%0d want 1/0", i, wr, bad); end
    end
  endtask

  task automatic test_ignore_start();
    int writes = 0;
    int lat = -1;
    logic [31:0] got = '0;
    bus.start = 1'b1; bus.op = 1'b0; bus.operand_a = 16'h1234; bus.operand_b = 16'h5678;
    @(posedge clock); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (bus.write_lo === 1'b1) begin writes++; lat = n; got = {bus.value_hi, bus.value_lo}; end
      if (n == 3) begin bus.start = 1'b1; bus.op = 1'b1; bus.operand_a = 16'h00FF; bus.operand_b = 16'h0; end
      if (n == 4) bus.start = 1'b0;
      @(posedge clock); #1;
    end
    n_checks++;
    if (writes !== 1 || lat !== 17) begin n_fail++; $display("FAIL ignore_start writes=%0d lat=%0d want 1/17", writes, lat); end
    n_checks++;
    if (got !== 32'h0626_0060) begin n_fail++; $display("FAIL ignore_start_value got=%h want=06260060", got); end
  endtask

  task automatic test_cancel();
    int writes = 0;
    logic busy_after = 1'b1;
    bus.start = 1'b1; bus.op = 1'b1; bus.operand_a = 16'd1000; bus.operand_b = 16'd3;
    @(posedge clock); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (bus.write_lo === 1'b1 || bus.write_hi === 1'b1 || bus.done === 1'b1) writes++;
      if (n == 5) bus.cancel = 1'b1;
      if (n == 6) begin busy_after = bus.busy; bus.cancel = 1'b0; end
      @(posedge clock); #1;
    end
    n_checks++;
    if (busy_after !== 1'b0) begin n_fail++; $display("FAIL cancel_busy got=%b want=0", busy_after); end
    n_checks++;
    if (writes !== 0) begin n_fail++; $display("FAIL cancel_no_write got=%0d want=0", writes); end
  endtask

  task automatic test_cancel_corners();
    int lat = -1;
    logic [15:0] lo = '0;
    // cancel held in IDLE does nothing
    bus.cancel = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL cancel_idle_busy got=%b want=0", bus.busy); end
    // start+cancel together: divide by zero goes to WRITE, cancel there is ignored
    bus.start = 1'b1; bus.op = 1'b1; bus.operand_a = 16'h00AA; bus.operand_b = 16'h0;
    @(posedge clock); #1;
    bus.start = 1'b0;
    n_checks++;
    if ({bus.write_lo, bus.value_hi, bus.overflow} !== {1'b1, 16'h00AA, 1'b1}) begin
      n_fail++; $display("FAIL cancel_in_write got wr=%b hi=%h ovf=%b want 1/00aa/1", bus.write_lo, bus.value_hi, bus.overflow);
    end
    @(posedge clock); #1;
    n_checks++;
    if ({bus.busy, bus.write_lo} !== 2'b00) begin n_fail++; $display("FAIL after_write got=%b want=00", {bus.busy, bus.write_lo}); end
    // start+cancel together on multiply is accepted
    bus.start = 1'b1; bus.op = 1'b0; bus.operand_a = 16'd300; bus.operand_b = 16'd500;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.cancel = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      if (bus.write_lo === 1'b1 && lat < 0) begin lat = n; lo = bus.value_lo; end
      @(posedge clock); #1;
    end
    n_checks++;
    if (lat !== 17 || lo !== 16'(32'd150000)) begin
      n_fail++; $display("FAIL start_with_cancel lat=%0d lo=%h want 17/%h", lat, lo, 16'(32'd150000));
    end
  endtask

  task automatic test_reset_mid_run();
    int writes = 0;
    int busy_seen = 0;
    int lat, bc, wr, bad;
    logic [15:0] lo, hi;
    logic [3:0] flg;
    bus.start = 1'b1; bus.op = 1'b0; bus.operand_a = 16'hBEEF; bus.operand_b = 16'hCAFE;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if (all_outs() !== 40'h0) begin n_fail++; $display("FAIL reset_mid_run got=%h want=0", all_outs()); end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int n = 0; n < 25; n++) begin
      if (bus.write_lo === 1'b1) writes++;
      if (bus.busy === 1'b1) busy_seen++;
      @(posedge clock); #1;
    end
    n_checks++;
    if (writes !== 0 || busy_seen !== 0) begin
      n_fail++; $display("FAIL reset_no_write writes=%0d busy=%0d want 0/0", writes, busy_seen);
    end
    run_op(1'b0, 16'd3, 16'd4, 1'b0, lat, lo, hi, flg, bc, wr, bad);
    n_checks++;
    if ({hi, lo} !== 32'h0000_000C || lat !== 17) begin
      n_fail++; $display("FAIL post_reset_mul got=%h_%h lat=%0d want 0000_000c/17", hi, lo, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_cancel();
    test_cancel_corners();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
